// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning HI/LO
// Results are computed at issue, held internally, and committed to HI/LO when busy drops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp_E,
    input  logic        start_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        exc_req,
    output logic        busy_E,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut_E
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   res_hi, res_lo;
    logic          res_we;
    logic          accept, is_mult, is_signed, done, div_zero, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, uq, ur, q, r;
    logic [63:0]   prod;

    assign is_mult   = MDOp_E == 4'd1 || MDOp_E == 4'd2;
    assign is_signed = MDOp_E == 4'd1 || MDOp_E == 4'd3;
    assign busy_E    = state == BUSY;
    assign accept    = start_E && !busy_E && !exc_req && MDOp_E >= 4'd1 && MDOp_E <= 4'd4;
    assign done      = busy_E && cnt == CW'(1);
    // One 64-bit multiplier serves both signednesses via operand extension.
    assign prod = {{32{is_signed & A_E[31]}}, A_E} * {{32{is_signed & B_E[31]}}, B_E};
    // Signed divide through magnitudes; INT_MIN / -1 yields 0x80000000 with no special case.
    assign a_neg    = is_signed & A_E[31];
    assign b_neg    = is_signed & B_E[31];
    assign a_mag    = a_neg ? -A_E : A_E;
    assign b_mag    = b_neg ? -B_E : B_E;
    assign div_zero = B_E == 32'd0;
    assign uq       = div_zero ? 32'd0 : a_mag / b_mag;
    assign ur       = div_zero ? 32'd0 : a_mag % b_mag;
    assign q        = (a_neg ^ b_neg) ? -uq : uq;
    assign r        = a_neg ? -ur : ur;
    assign MDOut_E  = MDOp_E == 4'd7 ? HI : MDOp_E == 4'd8 ? LO : 32'd0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE && accept) begin
            state_n = BUSY;
            cnt_n   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (state == BUSY) begin
            state_n = done ? IDLE : BUSY;
            cnt_n   = done ? '0 : cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                res_hi <= is_mult ? prod[63:32] : r;
                res_lo <= is_mult ? prod[31:0] : q;
                res_we <= is_mult || !div_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done && res_we) begin
            HI <= res_hi;
            LO <= res_lo;
        end else if (!busy_E && !exc_req) begin
            if (MDOp_E == 4'd5) HI <= A_E;
            if (MDOp_E == 4'd6) LO <= A_E;
        end
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit of the P7 MIPS pipeline; owns the HI/LO registers.
- Executes mult/multu/div/divu over multiple cycles, and mthi/mtlo in a single cycle.
- Supplies mfhi/mflo read data to the E→M pipeline register.
- Exports busy_E/start_E to the hazard unit, which stalls any D-stage HI/LO instruction while either is high.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu
DIV_CYCLES, 10, cycles busy stays high for div/divu

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
MDOp_E  input  4  op select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; other values behave as none
start_E  input  1  from E-stage controller; high exactly when MDOp_E is 1..4
A_E  input  32  forwarded rs value (MF_rs_E)
B_E  input  32  forwarded rt value (MF_rt_E)
exc_req  input  1  exception/interrupt taken this cycle; E-stage instruction is being flushed
busy_E  output  1  multi-cycle operation in flight
HI  output  32  HI register
LO  output  32  LO register
MDOut_E  output  32  HI when MDOp_E==7, LO when MDOp_E==8, else 0 (combinational)

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy_E=0, counter=0, internal result registers=0. Reset mid-operation aborts it; HI/LO stay 0.
- Accept condition: start_E & ~busy_E & ~exc_req & MDOp_E in 1..4.
- On accept, at the rising edge:
  - compute the full result from A_E/B_E into internal res_hi/res_lo;
  - busy_E<=1;
  - counter<=MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Later changes on A_E/B_E do not affect the result.
- While busy_E=1, each edge: if counter==1 then HI<=res_hi, LO<=res_lo, busy_E<=0, counter<=0; else counter<=counter-1.
- Net timing: busy_E is high for exactly N cycles; new HI/LO are visible in the same cycle busy_E falls. An mfhi in D is released by the hazard unit in that cycle.
- FSM: IDLE (busy=0) → BUSY on accept; BUSY → IDLE when counter reaches 1. No other states.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned. HI=product[63:32], LO=product[31:0].
  - div: signed, quotient truncated toward zero → LO; remainder takes the sign of the dividend → HI.
  - divu: unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero: busy runs the full DIV_CYCLES; HI/LO are left unchanged at completion (no write).
- mthi/mtlo:
  - When MDOp_E is 5 or 6 and ~busy_E & ~exc_req: HI (or LO) <= A_E at the edge, one cycle, busy stays 0.
  - Ignored while busy_E=1; the hazard unit guarantees this cannot occur, and the RTL must still drop it.
- exc_req:
  - Suppresses accept and mthi/mtlo writes in that cycle.
  - Does NOT cancel an operation already in flight; it completes and writes HI/LO, per MIPS precise-exception semantics for issued mult/div.
- start_E while busy_E=1: ignored; no restart, no counter reload.
- MDOut_E reads the current HI/LO register values. No internal bypass is needed because the stall covers the hazards.
- Back-to-back: a new start accepted in the cycle busy_E falls uses a fresh result; the completing write and the new capture happen on the same edge without conflict.

Test Plan:
- Reset held, then released mid-run: assert reset 2 cycles after a div start (A=100, B=7) → busy_E=0 and HI=LO=0 immediately; after release, MDOut_E with MDOp_E=7 returns 0.
- Signed mult timing: mult A=0xFFFFFFFE (-2), B=3 at cycle 0 → busy_E high cycles 1–5; in cycle 6, busy_E=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Signed division: div A=-7 (0xFFFFFFF9), B=2 → busy_E high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also check INT_MIN/-1 → LO=0x80000000, HI=0. With HI=LO=0x12345678, divu A=5, B=0 → after 10 busy cycles HI/LO still 0x12345678.
- Ignore rules: mtlo A=0xDEADBEEF with busy_E=0 → LO=0xDEADBEEF next cycle, busy_E stays 0. Second start_E (mult 9×9) while busy from a div → ignored; the div result lands and counter is unaffected.
- exc_req: mult 4×4 with exc_req=1 in the start cycle → busy_E stays 0, HI/LO unchanged. mult 4×4 accepted, then exc_req=1 in cycle 2 → completes on schedule, LO=16, HI=0.
- Back-to-back: mult 2×3, then divu 20/6 started in the cycle busy_E falls → after the mult, LO=6; after 10 more busy cycles, LO=3, HI=2.
